freq_gate_ctrl: RTL and testbench

Gate-time controller for the frequency meter. It sequences the 4-digit BCD event counter through a repeating clear → count-gate → settle → latch cycle. It captures each finished count into a stable display register. It selects the gate length (1 ms to 1 s in decades) either manually or by auto-ranging on the latched count. It sits between the system clock domain, the counter's `counter_en`/`reset` pins and the display driver.

---
 rtl/freq_gate_ctrl_if.sv | 25 ++
 rtl/freq_gate_ctrl.sv | 110 +++++++++++
 tb/tb_freq_gate_ctrl.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/freq_gate_ctrl_if.sv
// Control/data bundle between the gate-time controller and its surroundings
// (run control, BCD counter pins, display register).
interface freq_gate_ctrl_if;
  logic        start;
  logic        auto_en;
  logic [1:0]  range_sel;
  logic [15:0] cnt_in;
  logic        counter_en;
  logic        cnt_rst_n;
  logic [15:0] result;
  logic [1:0]  range_out;
  logic        overflow;
  logic        result_valid;
  logic        busy;

  modport master (
    output start, auto_en, range_sel, cnt_in,
    input  counter_en, cnt_rst_n, result, range_out, overflow, result_valid, busy
  );

  modport slave (
    input  start, auto_en, range_sel, cnt_in,
    output counter_en, cnt_rst_n, result, range_out, overflow, result_valid, busy
  );
endinterface

// File: rtl/freq_gate_ctrl.sv
// Gate-time sequencer for the BCD frequency counter: clear -> gate -> settle ->
// latch -> evaluate, with manual or auto-ranging decade gate length.
module freq_gate_ctrl #(
  parameter int unsigned BASE_CYC   = 50000,
  parameter int unsigned CLR_CYC    = 4,
  parameter int unsigned SETTLE_CYC = 4
) (
  input  logic            clk,
  input  logic            reset,
  freq_gate_ctrl_if.slave bus
);

  typedef enum logic [2:0] {IDLE, CLEAR, GATE, SETTLE, LATCH, EVAL} state_t;

  state_t      state, state_nxt;
  logic [31:0] cnt, cnt_nxt;
  logic [1:0]  rng, rng_nxt;

  function automatic logic [31:0] gate_len(input logic [1:0] r);
    case (r)
      2'd0:    gate_len = BASE_CYC;
      2'd1:    gate_len = BASE_CYC * 32'd10;
      2'd2:    gate_len = BASE_CYC * 32'd100;
      default: gate_len = BASE_CYC * 32'd1000;
    endcase
  endfunction

  // One shared down-counter times CLEAR, GATE and SETTLE; it is reloaded on
  // each state entry and the state advances when it reaches zero.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rng_nxt   = rng;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = CLEAR;
          cnt_nxt   = CLR_CYC - 32'd1;
          if (!bus.auto_en) rng_nxt = bus.range_sel;
        end
      end
      CLEAR: begin
        if (cnt == 32'd0) begin
          state_nxt = GATE;
          cnt_nxt   = gate_len(rng) - 32'd1;
        end else begin
          cnt_nxt = cnt - 32'd1;
        end
      end
      GATE: begin
        if (cnt == 32'd0) begin
          state_nxt = SETTLE;
          cnt_nxt   = SETTLE_CYC - 32'd1;
        end else begin
          cnt_nxt = cnt - 32'd1;
        end
      end
      SETTLE: begin
        if (cnt == 32'd0) state_nxt = LATCH;
        else              cnt_nxt = cnt - 32'd1;
      end
      LATCH: state_nxt = EVAL;
      EVAL: begin
        // Auto-range decision uses the value latched one cycle earlier.
        if (bus.auto_en) begin
          if (bus.overflow && rng != 2'd0)                     rng_nxt = rng - 2'd1;
          else if (bus.result[15:12] == 4'd0 && rng != 2'd3)   rng_nxt = rng + 2'd1;
        end
        if (bus.start) begin
          state_nxt = CLEAR;
          cnt_nxt   = CLR_CYC - 32'd1;
          if (!bus.auto_en) rng_nxt = bus.range_sel;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are flops decoded from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      cnt              <= 32'd0;
      rng              <= 2'd3;
      bus.counter_en   <= 1'b0;
      bus.cnt_rst_n    <= 1'b1;
      bus.busy         <= 1'b0;
      bus.result       <= 16'd0;
      bus.range_out    <= 2'd3;
      bus.overflow     <= 1'b0;
      bus.result_valid <= 1'b0;
    end else begin
      state            <= state_nxt;
      cnt              <= cnt_nxt;
      rng              <= rng_nxt;
      bus.counter_en   <= (state_nxt == GATE);
      bus.cnt_rst_n    <= (state_nxt != CLEAR);
      bus.busy         <= (state_nxt != IDLE);
      bus.result_valid <= (state == LATCH);
      if (state == LATCH) begin
        bus.result    <= bus.cnt_in;
        bus.range_out <= rng;
        bus.overflow  <= (bus.cnt_in[15:12] > 4'd9);
      end
    end
  end

endmodule

// File: tb/tb_freq_gate_ctrl.sv
// Bench for freq_gate_ctrl: a measurement-timeline model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_freq_gate_ctrl;
  localparam int BASE = 10;
  localparam int CLR  = 2;
  localparam int SET  = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  freq_gate_ctrl_if bus();

  freq_gate_ctrl #(.BASE_CYC(BASE), .CLR_CYC(CLR), .SETTLE_CYC(SET)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Model: position m_p counts cycles since CLEAR entry within one measurement.
  bit          m_valid = 0;
  bit          m_act   = 0;
  int          m_p     = 0;
  int          m_rng   = 3;
  int          m_g     = BASE;
  logic [15:0] m_res   = 16'd0;
  int          m_ro    = 3;
  bit          m_ovf   = 0;

  function automatic int glen(input int r);
    int g = BASE;
    for (int i = 0; i < r; i++) g = g * 10;
    return g;
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      m_valid = 1; m_act = 0; m_p = 0; m_rng = 3; m_res = 16'd0; m_ro = 3; m_ovf = 0;
    end else if (m_valid) begin
      if (!m_act) begin
        if (bus.start) begin
          m_act = 1; m_p = 0;
          if (!bus.auto_en) m_rng = bus.range_sel;
          m_g = glen(m_rng);
        end
      end else if (m_p == CLR + m_g + SET) begin
        m_res = bus.cnt_in; m_ro = m_rng; m_ovf = (bus.cnt_in[15:12] > 9);
        m_p++;
      end else if (m_p == CLR + m_g + SET + 1) begin
        if (bus.auto_en) begin
          if (m_ovf && m_rng > 0)                   m_rng--;
          else if (m_res[15:12] == 0 && m_rng < 3)  m_rng++;
        end
        if (bus.start) begin
          m_p = 0;
          if (!bus.auto_en) m_rng = bus.range_sel;
          m_g = glen(m_rng);
        end else begin
          m_act = 0;
        end
      end else begin
        m_p++;
      end
    end
  end

  int ce_run = 0, last_gate = 0, clr_run = 0, last_clr = 0;

  always @(negedge clk) begin
    if (m_valid) begin
      chk("busy",         bus.busy,         m_act);
      chk("counter_en",   bus.counter_en,   m_act && m_p >= CLR && m_p < CLR + m_g);
      chk("cnt_rst_n",    bus.cnt_rst_n,    !(m_act && m_p < CLR));
      chk("result_valid", bus.result_valid, m_act && m_p == CLR + m_g + SET + 1);
      chk("result",       bus.result,       m_res);
      chk("range_out",    bus.range_out,    m_ro);
      chk("overflow",     bus.overflow,     m_ovf);
    end
    if (bus.counter_en === 1'b1) ce_run++;
    else if (ce_run > 0) begin last_gate = ce_run; ce_run = 0; end
    if (bus.cnt_rst_n === 1'b0) clr_run++;
    else if (clr_run > 0) begin last_clr = clr_run; clr_run = 0; end
  end

  task automatic wait_rv(input int budget);
    int n = 0;
    @(negedge clk);
    while (bus.result_valid !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (bus.result_valid !== 1'b1) chk("rv_timeout", bus.result_valid, 1);
    #1;
  endtask

  task automatic wait_ce(input int budget);
    int n = 0;
    @(negedge clk);
    while (bus.counter_en !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (bus.counter_en !== 1'b1) chk("ce_timeout", bus.counter_en, 1);
    #1;
  endtask

  int t1;

  initial begin
    bus.start = 0; bus.auto_en = 0; bus.range_sel = 2'd0; bus.cnt_in = 16'd0;
    repeat (3) @(negedge clk);
    chk("rst_range_out", bus.range_out, 3);
    chk("rst_busy",      bus.busy, 0);
    chk("rst_cnt_rst_n", bus.cnt_rst_n, 1);
    chk("rst_result",    bus.result, 0);

    // Manual range 0, continuous run
    reset = 0; bus.cnt_in = 16'h1234; bus.start = 1;
    wait_rv(100);
    t1 = cyc;
    wait_rv(100);
    chk("rv_period",  cyc - t1, 17);
    chk("gate_len_0", last_gate, 10);
    chk("clr_len",    last_clr, 2);
    chk("res_1234",   bus.result, 16'h1234);
    chk("ro_0",       bus.range_out, 0);
    chk("ovf_0",      bus.overflow, 0);

    // range_sel change mid-gate only affects the following window
    wait_ce(30);
    bus.range_sel = 2'd1;
    wait_rv(100);
    chk("gate_keep_10", last_gate, 10);
    wait_rv(300);
    chk("gate_100", last_gate, 100);
    chk("ro_1",     bus.range_out, 1);

    // start dropped mid-gate: measurement finishes, then idle
    wait_ce(30);
    bus.start = 0;
    wait_rv(300);
    chk("drop_ro", bus.range_out, 1);
    repeat (3) @(negedge clk);
    chk("drop_busy", bus.busy, 0);
    chk("drop_ce",   bus.counter_en, 0);

    // reset in the middle of a gate
    bus.range_sel = 2'd0; bus.start = 1;
    wait_ce(30);
    repeat (3) @(negedge clk);
    reset = 1;
    @(negedge clk);
    chk("rst_gate_ce",   bus.counter_en, 0);
    chk("rst_gate_busy", bus.busy, 0);
    chk("rst_gate_res",  bus.result, 0);
    chk("rst_gate_ro",   bus.range_out, 3);
    chk("rst_gate_rv",   bus.result_valid, 0);

    // Auto-range from reset range 3 with an overflowing count
    bus.auto_en = 1; bus.cnt_in = 16'hA000;
    reset = 0;
    wait_rv(11000);
    chk("auto_gate_3", last_gate, 10000);
    chk("auto_ovf",    bus.overflow, 1);
    chk("auto_ro_3",   bus.range_out, 3);
    chk("auto_res",    bus.result, 16'hA000);
    wait_rv(1100);
    chk("auto_gate_2", last_gate, 1000);
    chk("auto_ro_2",   bus.range_out, 2);

    // d3 in 1..9 holds the range
    bus.cnt_in = 16'h5000;
    wait_rv(200);
    chk("hold_gate_a", last_gate, 100);
    wait_rv(200);
    chk("hold_gate_b", last_gate, 100);
    chk("hold_ovf",    bus.overflow, 0);

    // d3 == 0 steps the range up until it saturates at 3
    bus.cnt_in = 16'h0500;
    wait_rv(200);
    chk("up_gate_1", last_gate, 100);
    wait_rv(1100);
    chk("up_gate_2", last_gate, 1000);
    wait_rv(10100);
    chk("up_gate_3", last_gate, 10000);
    wait_rv(10100);
    chk("up_gate_3b", last_gate, 10000);
    chk("up_ro_3",    bus.range_out, 3);

    // Randomized traffic, model checks every cycle
    reset = 1; bus.start = 0; bus.auto_en = 0;
    @(negedge clk);
    reset = 0;
    for (int i = 0; i < 4000; i++) begin
      bus.cnt_in = 16'($urandom);
      if ($urandom_range(0, 99) < 4)   bus.start = ~bus.start;
      if ($urandom_range(0, 99) < 5)   bus.range_sel = 2'($urandom_range(0, 1));
      if ($urandom_range(0, 999) < 5)  bus.auto_en = ~bus.auto_en;
      reset = ($urandom_range(0, 999) < 3);
      @(negedge clk);
    end
    reset = 0;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
